spatial_mult_accumulator: RTL and testbench
===========================================

Name: spatial_mult_accumulator

Overview:
- Sits directly downstream of the signed spatial multiplier.
- Consumes its signed product stream (2*PRECISION+2 bits) and accumulates a programmable number of products into a wide signed accumulator.
- Presents the finished dot-product with a valid/ready handshake to the output buffer.
- Sequential control: IDLE/ACCUM/DONE state machine, term counter, sticky overflow flag.

Parameters:
- PRECISION, 8, top-level multiplier precision; sets the product width.
- PROD_WIDTH, PRECISION*2+2, width of the signed product input (18 by default).
- ACC_WIDTH, 32, width of the signed accumulator and result; must be >= PROD_WIDTH.
- CNT_WIDTH, 16, width of the term-count input and internal counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- start  input  1  begin new accumulation; sampled only in IDLE.
- num_terms  input  CNT_WIDTH  number of products to accumulate; latched on accepted start.
- prod_valid  input  1  product on prod is valid.
- prod  input  PROD_WIDTH  signed product from the multiplier.
- prod_ready  output  1  block accepts a product this cycle.
- acc_valid  output  1  result on acc_data is valid.
- acc_data  output  ACC_WIDTH  signed accumulated result.
- acc_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state != IDLE.
- overflow  output  1  sticky flag: signed overflow occurred during the current accumulation.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, accumulator=0, counter=0, prod_ready=0, acc_valid=0, acc_data=0, busy=0, overflow=0. Reset mid-operation abandons the accumulation; no result is emitted.
- IDLE:
  - prod_ready=0, acc_valid=0.
  - start=1 latches num_terms, clears accumulator and overflow, and sets counter=0.
  - Next state is ACCUM, or DONE directly if num_terms==0 (result 0).
- ACCUM:
  - prod_ready=1.
  - Each cycle with prod_valid&&prod_ready: accumulator += sign-extended prod, counter += 1.
  - Accepting the product that makes counter==num_terms moves to DONE the next cycle.
  - prod_valid=0 stalls with no state change.
  - start is ignored.
- DONE:
  - acc_valid=1; acc_data holds the accumulator, stable until the handshake.
  - prod_ready=0.
  - acc_valid&&acc_ready returns to IDLE next cycle; acc_valid drops that cycle.
  - start asserted in the same cycle as the handshake is ignored; it must be re-presented in IDLE.
- Latency:
  - acc_valid rises exactly one cycle after the last product is accepted.
  - Throughput is one product per cycle in ACCUM.
  - Minimum IDLE->IDLE cycle is num_terms+2 cycles when acc_ready is held at 1.
- Arithmetic:
  - Two's complement; product sign-extended to ACC_WIDTH+1 for the add.
  - Overflow is detected when both operands share a sign and the sum's sign differs.
  - Default behaviour wraps modulo 2^ACC_WIDTH; overflow is set and held until the next accepted start or reset.
- Counter: compares against the latched num_terms, so num_terms changing during ACCUM has no effect. num_terms=2^CNT_WIDTH-1 is supported without counter wrap.

Optional Feature:
- Macro SPATIAL_MULT_ACC_SATURATE_EN.
- When defined, an overflowing add clamps the accumulator to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), depending on the overflow direction. Subsequent adds continue from the clamped value, and overflow is still set sticky.
- When undefined, the accumulator wraps as above. No saturation logic is instantiated.

Test Plan:
- Reset, then start with num_terms=4; products 100, -30, 7, -1 with prod_valid held high -> acc_valid 1 cycle after 4th accept, acc_data=76, overflow=0, busy falls after acc_ready handshake.
- num_terms=3; products with prod_valid gapped (1,0,0,1,0,1) on values -131072 (min 18-bit), -131072, 5 -> acc_data=-262139; prod_ready high throughout ACCUM; counter only advances on accepted beats.
- start with num_terms=0 -> DONE next cycle, acc_valid=1, acc_data=0; hold acc_ready=0 for 5 cycles -> acc_valid and acc_data stable; then acc_ready=1 -> IDLE.
- ACC_WIDTH=18 build; accumulate 131071 twice -> without macro, acc_data wraps to -2 and overflow=1; with SPATIAL_MULT_ACC_SATURATE_EN, acc_data=131071 and overflow=1; next start clears overflow.
- Assert reset=0 after 2 of 5 products accepted -> next cycle busy=0, acc_valid=0, accumulator=0; a new start with num_terms=1 and product 9 -> acc_data=9.
- start pulsed during ACCUM and during the DONE handshake cycle -> ignored; num_terms changed mid-ACCUM -> original count honoured.

Source files
------------

// File: rtl/spatial_mult_accumulator_if.sv
// Product-in / result-out handshake bundle for spatial_mult_accumulator.
// slave = accumulator side, master = producer/consumer side.
interface spatial_mult_accumulator_if #(
    parameter int PROD_WIDTH = 18,
    parameter int ACC_WIDTH  = 32
);
    logic                  prod_valid;
    logic [PROD_WIDTH-1:0] prod;
    logic                  prod_ready;
    logic                  acc_valid;
    logic [ACC_WIDTH-1:0]  acc_data;
    logic                  acc_ready;

    modport slave (
        input  prod_valid, prod, acc_ready,
        output prod_ready, acc_valid, acc_data
    );

    modport master (
        output prod_valid, prod, acc_ready,
        input  prod_ready, acc_valid, acc_data
    );
endinterface

// File: rtl/spatial_mult_accumulator.sv
// Accumulates num_terms signed products into a wide accumulator and hands the sum out.
// Define SPATIAL_MULT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module spatial_mult_accumulator #(
    parameter int PRECISION  = 8,
    parameter int PROD_WIDTH = PRECISION*2+2,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_terms,
    spatial_mult_accumulator_if.slave bus,
    output logic                  busy,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] nterms_q, nterms_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 add_ovf;
    logic [ACC_WIDTH-1:0] add_res;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign prod_ext = ACC_WIDTH'($signed(bus.prod));
    assign sum      = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
    // Extra sum bit disagrees with the result sign exactly when same-sign operands flip sign.
    assign add_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign cnt_inc  = cnt_q + 1'b1;

`ifdef SPATIAL_MULT_ACC_SATURATE_EN
    always_comb begin
        add_res = sum[ACC_WIDTH-1:0];
        if (add_ovf)
            add_res = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    assign add_res = sum[ACC_WIDTH-1:0];
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        nterms_d       = nterms_q;
        ovf_d          = ovf_q;
        bus.prod_ready = 1'b0;
        bus.acc_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nterms_d = num_terms;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = (num_terms == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                bus.prod_ready = 1'b1;
                if (bus.prod_valid) begin
                    acc_d = add_res;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_inc;
                    if (cnt_inc == nterms_q)
                        state_d = DONE;
                end
            end
            DONE: begin
                bus.acc_valid = 1'b1;
                if (bus.acc_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            nterms_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            nterms_q <= nterms_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.acc_data = acc_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_spatial_mult_accumulator.sv
// Scoreboard bench: a 32-bit accumulator instance for the main flows and an 18-bit one for overflow.
module tb_spatial_mult_accumulator;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, start18 = 1'b0;
    logic [15:0] nt = '0, nt18 = '0;
    logic        busy, ovf, busy18, ovf18;

    spatial_mult_accumulator_if #(.PROD_WIDTH(18), .ACC_WIDTH(32)) b32();
    spatial_mult_accumulator_if #(.PROD_WIDTH(18), .ACC_WIDTH(18)) b18();

    spatial_mult_accumulator #(.PRECISION(8), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .num_terms(nt),
        .bus(b32.slave), .busy(busy), .overflow(ovf)
    );
    spatial_mult_accumulator #(.PRECISION(8), .ACC_WIDTH(18), .CNT_WIDTH(16)) dut18 (
        .clk(clk), .reset(reset), .start(start18), .num_terms(nt18),
        .bus(b18.slave), .busy(busy18), .overflow(ovf18)
    );

    int   checks = 0, errors = 0;
    int   sb_data[$];
    logic sb_ovf[$];
    int   exp_d;
    logic exp_o;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        start = 1'b1;
        nt    = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        b32.prod_valid = 1'b0; b32.prod = '0; b32.acc_ready = 1'b0;
        b18.prod_valid = 1'b0; b18.prod = '0; b18.acc_ready = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || busy18 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b/%b exp 0", busy, busy18); end
        checks++; if (b32.acc_valid !== 1'b0 || b32.prod_ready !== 1'b0) begin errors++; $display("FAIL rst_hs got v=%b r=%b exp 0", b32.acc_valid, b32.prod_ready); end
        checks++; if (b32.acc_data !== 32'd0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_data got %0d ovf=%b exp 0", b32.acc_data, ovf); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int vals[4] = '{100, -30, 7, -1};
        sb_data.push_back(76); sb_ovf.push_back(1'b0);
        go(4);
        checks++; if (busy !== 1'b1 || b32.prod_ready !== 1'b1) begin errors++; $display("FAIL basic_accum got busy=%b rdy=%b exp 1", busy, b32.prod_ready); end
        b32.prod_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b32.prod = 18'(vals[i]);
            tick();
        end
        b32.prod_valid = 1'b0;
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b32.acc_valid !== 1'b1 || b32.prod_ready !== 1'b0) begin errors++; $display("FAIL basic_latency got v=%b r=%b exp v=1 r=0", b32.acc_valid, b32.prod_ready); end
        checks++; if (b32.acc_data !== 32'(exp_d) || ovf !== exp_o) begin errors++; $display("FAIL basic_data got %0d ovf=%b exp %0d ovf=%b", $signed(b32.acc_data), ovf, exp_d, exp_o); end
        b32.acc_ready = 1'b1;
        tick();
        b32.acc_ready = 1'b0;
        checks++; if (busy !== 1'b0 || b32.acc_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b v=%b exp 0", busy, b32.acc_valid); end
    endtask

    task automatic test_gapped();
        logic vld[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   vals[6] = '{-131072, 0, 0, -131072, 0, 5};
        int   bad = 0;
        sb_data.push_back(-262139); sb_ovf.push_back(1'b0);
        go(3);
        for (int i = 0; i < 6; i++) begin
            if (b32.prod_ready !== 1'b1 || b32.acc_valid !== 1'b0) bad++;
            b32.prod_valid = vld[i];
            b32.prod       = 18'(vals[i]);
            tick();
        end
        b32.prod_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL gap_ready got %0d bad beats exp 0", bad); end
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b32.acc_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", b32.acc_valid); end
        checks++; if (b32.acc_data !== 32'(exp_d) || ovf !== exp_o) begin errors++; $display("FAIL gap_data got %0d ovf=%b exp %0d ovf=%b", $signed(b32.acc_data), ovf, exp_d, exp_o); end
        b32.acc_ready = 1'b1;
        tick();
        b32.acc_ready = 1'b0;
    endtask

    task automatic test_zero_terms();
        int bad = 0;
        sb_data.push_back(0); sb_ovf.push_back(1'b0);
        b32.prod = 18'd77;
        go(0);
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b32.acc_valid !== 1'b1 || b32.acc_data !== 32'(exp_d)) begin errors++; $display("FAIL zero_done got v=%b d=%0d exp v=1 d=%0d", b32.acc_valid, $signed(b32.acc_data), exp_d); end
        repeat (5) begin
            tick();
            if (b32.acc_valid !== 1'b1 || b32.acc_data !== 32'(exp_d)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_stall got %0d unstable cycles exp 0", bad); end
        b32.acc_ready = 1'b1;
        tick();
        b32.acc_ready = 1'b0;
        checks++; if (busy !== 1'b0 || b32.acc_valid !== 1'b0) begin errors++; $display("FAIL zero_idle got busy=%b v=%b exp 0", busy, b32.acc_valid); end
    endtask

    task automatic test_overflow();
`ifdef SPATIAL_MULT_ACC_SATURATE_EN
        sb_data.push_back(131071);
`else
        sb_data.push_back(-2);
`endif
        sb_ovf.push_back(1'b1);
        start18 = 1'b1; nt18 = 16'd2; tick(); start18 = 1'b0;
        b18.prod_valid = 1'b1; b18.prod = 18'(131071);
        repeat (2) tick();
        b18.prod_valid = 1'b0;
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b18.acc_valid !== 1'b1 || b18.acc_data !== 18'(exp_d)) begin errors++; $display("FAIL ovf_data got v=%b d=%0d exp v=1 d=%0d", b18.acc_valid, $signed(b18.acc_data), exp_d); end
        checks++; if (ovf18 !== exp_o) begin errors++; $display("FAIL ovf_flag got %b exp %b", ovf18, exp_o); end
        b18.acc_ready = 1'b1; tick(); b18.acc_ready = 1'b0;
        checks++; if (ovf18 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf18); end
        sb_data.push_back(1); sb_ovf.push_back(1'b0);
        start18 = 1'b1; nt18 = 16'd1; tick(); start18 = 1'b0;
        checks++; if (ovf18 !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf18); end
        b18.prod_valid = 1'b1; b18.prod = 18'd1; tick(); b18.prod_valid = 1'b0;
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b18.acc_data !== 18'(exp_d) || ovf18 !== exp_o) begin errors++; $display("FAIL ovf_next got %0d ovf=%b exp %0d ovf=%b", $signed(b18.acc_data), ovf18, exp_d, exp_o); end
        b18.acc_ready = 1'b1; tick(); b18.acc_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        go(5);
        b32.prod_valid = 1'b1;
        b32.prod = 18'd3; tick();
        b32.prod = 18'd4; tick();
        b32.prod_valid = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (busy !== 1'b0 || b32.acc_valid !== 1'b0 || b32.acc_data !== 32'd0) begin errors++; $display("FAIL mid_reset got busy=%b v=%b d=%0d exp 0", busy, b32.acc_valid, b32.acc_data); end
        sb_data.push_back(9); sb_ovf.push_back(1'b0);
        go(1);
        b32.prod_valid = 1'b1; b32.prod = 18'd9; tick(); b32.prod_valid = 1'b0;
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b32.acc_valid !== 1'b1 || b32.acc_data !== 32'(exp_d)) begin errors++; $display("FAIL mid_restart got v=%b d=%0d exp v=1 d=%0d", b32.acc_valid, $signed(b32.acc_data), exp_d); end
        b32.acc_ready = 1'b1; tick(); b32.acc_ready = 1'b0;
    endtask

    task automatic test_ignored_start();
        sb_data.push_back(60); sb_ovf.push_back(1'b0);
        go(3);
        b32.prod_valid = 1'b1; b32.prod = 18'd10;
        start = 1'b1; nt = 16'd1;
        tick();
        start = 1'b0;
        b32.prod = 18'd20; tick();
        checks++; if (b32.acc_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ign_count got v=%b busy=%b exp v=0 busy=1", b32.acc_valid, busy); end
        b32.prod = 18'd30; tick();
        b32.prod_valid = 1'b0;
        exp_d = sb_data.pop_front(); exp_o = sb_ovf.pop_front();
        checks++; if (b32.acc_valid !== 1'b1 || b32.acc_data !== 32'(exp_d)) begin errors++; $display("FAIL ign_data got v=%b d=%0d exp v=1 d=%0d", b32.acc_valid, $signed(b32.acc_data), exp_d); end
        start = 1'b1; nt = 16'd2; b32.acc_ready = 1'b1;
        tick();
        start = 1'b0; b32.acc_ready = 1'b0;
        checks++; if (busy !== 1'b0 || b32.acc_valid !== 1'b0) begin errors++; $display("FAIL ign_hs got busy=%b v=%b exp 0", busy, b32.acc_valid); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle got busy=%b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_zero_terms();
        test_overflow();
        test_reset_mid();
        test_ignored_start();
        checks++; if (sb_data.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb_data.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
